datapath_mem_seq: RTL
=====================

Name: datapath_mem_seq

Overview:
- Parametrised, sequenced successor to the 64-bit LEGv8 datapath with memory.
- Contains an internal register file, an ALU with a constant/B operand mux, and a word-addressed data RAM.
- Executes one micro-op at a time through a valid/ready handshake, using an FSM in place of externally driven tristate selects.
- Sits between the future instruction controller and the memory subsystem; load latency is configurable.

Parameters:
- DATA_W, 64, datapath/register/memory word width.
- REG_AW, 5, register index width; 2**REG_AW registers.
- MEM_AW, 8, RAM word-address width; 2**MEM_AW words.
- MEM_LAT, 2, load read latency in cycles (>=1).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  micro-op offered
- op_ready  out  1  block idle, can accept
- op_kind  in  2  00 ALU, 01 LOAD, 10 STORE, 11 reserved
- fs  in  3  ALU function
- cin  in  1  carry-in for ADD
- sel_k  in  1  1: ALU B operand = k; 0: R[sb]
- sa  in  REG_AW  A source register
- sb  in  REG_AW  B source / store data register
- da  in  REG_AW  destination register
- k  in  DATA_W  constant
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; reserved op_kind
- result  out  DATA_W  value written (ALU F / load data / store address, zero-extended)
- status  out  4  {V,C,N,Z} from last ALU op
- dbg_sel  in  REG_AW  debug register select
- dbg_data  out  DATA_W  combinational R[dbg_sel]

Behaviour:
- Reset (async): all registers=0, FSM=IDLE, op_ready=1, done=0, err=0, result=0, status=0, MEM_LAT counter=0. RAM contents are not reset.
- Handshake: accept on a rising edge with op_valid&&op_ready. op_ready=1 only in IDLE; all op fields are captured at accept, so later input changes are ignored.
- FSM: IDLE -> EXEC.
  - EXEC ALU: write R[da]=F, update status -> RESP.
  - EXEC STORE: mem[F[MEM_AW-1:0]] = R[sb] (always the register, regardless of sel_k) -> RESP.
  - EXEC LOAD: latch addr=F[MEM_AW-1:0], counter=MEM_LAT-1 -> MEM.
  - EXEC reserved: no write -> RESP with err=1.
  - MEM: decrement counter each cycle; at 0, write R[da]=mem[addr] -> RESP.
  - RESP: done=1 (err as set) for one cycle -> IDLE.
- Latency from accept edge to done-high cycle: ALU/STORE/reserved = done visible in the 2nd cycle after accept; LOAD = 2+MEM_LAT cycles. ALU throughput is one op per 3 cycles.
- ALU, B = sel_k ? k : R[sb]:
  - 0 AND
  - 1 OR
  - 2 ADD A+B+cin
  - 3 SUB A+~B+1
  - 4 XOR
  - 5 PASS B
  - 6 LSL A by B[5:0]
  - 7 LSR A by B[5:0]
  - Shift amounts >=DATA_W give 0.
- Status flags:
  - Z = F==0; N = F[DATA_W-1].
  - C = carry out for ADD/SUB, else 0; V = signed overflow for ADD/SUB, else 0.
  - Status changes only on ALU ops.
- Register file:
  - Reads are combinational.
  - Same-cycle write/read of a register returns the old value, which is irrelevant inside one op.
  - A register written by op N is visible to op N+1.
- Address wrap: only the low MEM_AW bits of F are used; higher bits are ignored.
- result updates at the same edge as the register/memory write and holds until the next op.
- Reset mid-op: abort immediately; no register or memory write occurs; done stays 0.

Optional Feature:
- DATAPATH_ZERO_REG_EN.
- Defined: register 2**REG_AW-1 (X31 at default) always reads 0, writes to it are discarded, and dbg_data reads 0 for it. result still shows the computed value.
- Undefined: the top register is an ordinary register.

Test Plan:
- Reset, then ALU ADD sel_k=1, k=5, sa=R0 (=0), da=1 -> done in 2nd cycle after accept, R1=5, result=5, status=0000; op_ready low for 2 cycles.
- SUB R1-R1 (sb=1, sel_k=0), da=2 -> R2=0, status Z=1, C=1.
- ADD with R1=64'h7FFF_FFFF_FFFF_FFFF and k=1 -> F=64'h8000_0000_0000_0000, V=1, N=1.
- STORE sa=R0, k=0x1F3, sb=R1 (=5) -> mem[0xF3]=5 (address wraps), result=0xF3. Then LOAD sa=R0, k=0xF3, da=3 -> done at cycle 2+MEM_LAT, R3=5.
- LOAD accepted, reset asserted during MEM -> R[da] unchanged, done never pulses, op_ready=1 right after reset; op_valid held through busy cycles is not double-accepted.
- op_kind=11 -> done=1, err=1, no register change. With DATAPATH_ZERO_REG_EN, ADD k=9 into da=31 -> dbg_data(31)=0.

Source files
------------

// File: rtl/datapath_mem_seq.sv
// Sequenced LEGv8-style datapath: register file, ALU, word RAM, valid/ready micro-op FSM.
// Build option: define DATAPATH_ZERO_REG_EN to hardwire the top register to zero.
module datapath_mem_seq #(
  parameter int DATA_W  = 64,
  parameter int REG_AW  = 5,
  parameter int MEM_AW  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_kind,
  input  logic [2:0]        fs,
  input  logic              cin,
  input  logic              sel_k,
  input  logic [REG_AW-1:0] sa,
  input  logic [REG_AW-1:0] sb,
  input  logic [REG_AW-1:0] da,
  input  logic [DATA_W-1:0] k,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        status,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << REG_AW;
  localparam int NMEM = 1 << MEM_AW;
  localparam int CW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] K_ALU   = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_kind;
  logic [2:0]        r_fs;
  logic              r_cin;
  logic              r_selk;
  logic [REG_AW-1:0] r_sa;
  logic [REG_AW-1:0] r_sb;
  logic [REG_AW-1:0] r_da;
  logic [DATA_W-1:0] r_k;
  logic [CW-1:0]     r_cnt;
  logic [MEM_AW-1:0] r_addr;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_status;
  logic [DATA_W-1:0] r_rf [NREG];
  logic [DATA_W-1:0] r_mem [NMEM];

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_sbv;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_add;
  logic [DATA_W:0]   w_sub;
  logic [DATA_W-1:0] w_f;
  logic              w_c;
  logic              w_v;
  logic [DATA_W-1:0] w_ld;
  logic [DATA_W-1:0] w_addr_ext;
  logic              w_zero_da;
  logic              w_mem_last;
  logic              w_rf_we;
  logic [DATA_W-1:0] w_rf_wd;
  logic              w_mem_we;

`ifdef DATAPATH_ZERO_REG_EN
  localparam logic [REG_AW-1:0] TOP = '1;
  assign w_a       = (r_sa == TOP) ? '0 : r_rf[r_sa];
  assign w_sbv     = (r_sb == TOP) ? '0 : r_rf[r_sb];
  assign dbg_data  = (dbg_sel == TOP) ? '0 : r_rf[dbg_sel];
  assign w_zero_da = (r_da == TOP);
`else
  assign w_a       = r_rf[r_sa];
  assign w_sbv     = r_rf[r_sb];
  assign dbg_data  = r_rf[dbg_sel];
  assign w_zero_da = 1'b0;
`endif

  assign w_b   = r_selk ? r_k : w_sbv;
  assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, r_cin};
  assign w_sub = {1'b0, w_a} + {1'b0, ~w_b} + {{DATA_W{1'b0}}, 1'b1};

  // Shifts use only B[5:0]; amounts past the word width fall out as zero.
  always_comb begin
    w_f = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    unique case (r_fs)
      3'd0: w_f = w_a & w_b;
      3'd1: w_f = w_a | w_b;
      3'd2: begin
        w_f = w_add[DATA_W-1:0];
        w_c = w_add[DATA_W];
        w_v = (w_a[DATA_W-1] == w_b[DATA_W-1]) &&
              (w_f[DATA_W-1] != w_a[DATA_W-1]);
      end
      3'd3: begin
        w_f = w_sub[DATA_W-1:0];
        w_c = w_sub[DATA_W];
        w_v = (w_a[DATA_W-1] != w_b[DATA_W-1]) &&
              (w_f[DATA_W-1] != w_a[DATA_W-1]);
      end
      3'd4: w_f = w_a ^ w_b;
      3'd5: w_f = w_b;
      3'd6: w_f = w_a << w_b[5:0];
      3'd7: w_f = w_a >> w_b[5:0];
    endcase
  end

  assign w_ld       = r_mem[r_addr];
  assign w_addr_ext = DATA_W'(w_f[MEM_AW-1:0]);
  assign w_mem_last = (r_state == S_MEM) && (r_cnt == '0);

  assign w_rf_we = !w_zero_da &&
                   (((r_state == S_EXEC) && (r_kind == K_ALU)) ||
                    w_mem_last);
  assign w_rf_wd = (r_state == S_MEM) ? w_ld : w_f;

  assign w_mem_we = !reset && (r_state == S_EXEC) &&
                    (r_kind == K_STORE);

  assign op_ready = (r_state == S_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign result   = r_result;
  assign status   = r_status;

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_f[MEM_AW-1:0]] <= w_sbv;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_rf_we) begin
      r_rf[r_da] <= w_rf_wd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_kind   <= '0;
      r_fs     <= '0;
      r_cin    <= 1'b0;
      r_selk   <= 1'b0;
      r_sa     <= '0;
      r_sb     <= '0;
      r_da     <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_status <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_kind  <= op_kind;
            r_fs    <= fs;
            r_cin   <= cin;
            r_selk  <= sel_k;
            r_sa    <= sa;
            r_sb    <= sb;
            r_da    <= da;
            r_k     <= k;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (r_kind)
            K_ALU: begin
              r_result <= w_f;
              r_status <= {w_v, w_c, w_f[DATA_W-1], w_f == '0};
              r_done   <= 1'b1;
              r_state  <= S_RESP;
            end
            K_STORE: begin
              r_result <= w_addr_ext;
              r_done   <= 1'b1;
              r_state  <= S_RESP;
            end
            K_LOAD: begin
              r_addr  <= w_f[MEM_AW-1:0];
              r_cnt   <= CNT_INIT;
              r_state <= S_MEM;
            end
            default: begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_RESP;
            end
          endcase
        end
        S_MEM: begin
          if (r_cnt == '0) begin
            r_result <= w_ld;
            r_done   <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
